adder_axi_master: RTL and testbench

- AXI4-Lite master that drives the adder register slave directly downstream.
- Accepts an operand pair on a valid/ready command port, writes operand A and operand B to the slave, then reads the sum back.
- Returns the sum and an error flag on a valid/ready result port.
- Sits between the test/control logic and the adder slave; one transaction in flight at a time.

---
 rtl/adder_axi_pkg.sv | 27 ++
 rtl/adder_axi_master_wr_chan.sv | 59 +++++
 rtl/adder_axi_master.sv | 176 +++++++++++++++++
 tb/tb_adder_axi_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_axi_pkg.sv
// Shared definitions for the adder AXI4-Lite master: register map, response codes, FSM states.
package adder_axi_pkg;

  localparam logic [7:0] ADDR_OPA    = 8'h00;
  localparam logic [7:0] ADDR_OPB    = 8'h04;
  localparam logic [7:0] ADDR_RESULT = 8'h08;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_A    = 3'd1,
    RESP_A  = 3'd2,
    WR_B    = 3'd3,
    RESP_B  = 3'd4,
    RD_ADDR = 3'd5,
    RD_DATA = 3'd6,
    DONE    = 3'd7
  } state_e;

  // Any response other than OKAY is treated as a failed access.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != OKAY);
  endfunction

endpackage

// File: rtl/adder_axi_master_wr_chan.sv
// One AXI4-Lite write (aw/w/b) with independent aw and w handshakes; reused for every register write.
module axi_lite_wr_chan #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wvalid,
  input  logic                  wready,
  output logic                  bready,
  input  logic                  bvalid,
  output logic                  phase_done
);

  logic phase_r;

  // Address/data phase ends when each channel has completed, now or earlier.
  assign phase_done = phase_r && (!awvalid || awready) && (!wvalid || wready);

  // Channel state: valids drop on their own handshake, bready opens once both are done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r <= 1'b0;
      awaddr  <= {ADDR_WIDTH{1'b0}};
      awvalid <= 1'b0;
      wdata   <= {DATA_WIDTH{1'b0}};
      wvalid  <= 1'b0;
      bready  <= 1'b0;
    end else if (start) begin
      phase_r <= 1'b1;
      awaddr  <= addr;
      awvalid <= 1'b1;
      wdata   <= data;
      wvalid  <= 1'b1;
      bready  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        awvalid <= 1'b0;
      end
      if (wvalid && wready) begin
        wvalid <= 1'b0;
      end
      if (phase_done) begin
        phase_r <= 1'b0;
        bready  <= 1'b1;
      end else if (bready && bvalid) begin
        bready  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adder_axi_master.sv
// AXI4-Lite master: writes operands A and B to the adder slave, reads the sum back, returns it.
module adder_axi_master
  import adder_axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    m0_axi_aclk,
  input  logic                    m0_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   cmd_a,
  input  logic [DATA_WIDTH-1:0]   cmd_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [DATA_WIDTH-1:0]   res_data,
  output logic                    res_err,
  output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
  output logic                    m0_axi_awvalid,
  input  logic                    m0_axi_awready,
  output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
  output logic                    m0_axi_wvalid,
  input  logic                    m0_axi_wready,
  input  logic [1:0]              m0_axi_bresp,
  input  logic                    m0_axi_bvalid,
  output logic                    m0_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
  output logic                    m0_axi_arvalid,
  input  logic                    m0_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
  input  logic [1:0]              m0_axi_rresp,
  input  logic                    m0_axi_rvalid,
  output logic                    m0_axi_rready
);

  state_e                  state_r;
  logic [DATA_WIDTH-1:0]   op_b_r;
  logic                    wr_start_s;
  logic [ADDR_WIDTH-1:0]   wr_addr_s;
  logic [DATA_WIDTH-1:0]   wr_data_s;
  logic                    wr_phase_done_s;
  logic                    b_fire_s;

  assign m0_axi_wstrb = {(DATA_WIDTH/8){1'b1}};
  assign b_fire_s     = m0_axi_bvalid && m0_axi_bready;

  // Launch a write on the accepting edge so awvalid/wvalid appear in the very next cycle.
  always_comb begin
    wr_start_s = 1'b0;
    wr_addr_s  = ADDR_WIDTH'(ADDR_OPA);
    wr_data_s  = cmd_a;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready) wr_start_s = 1'b1;
        else                        wr_start_s = 1'b0;
      end
      RESP_A: begin
        wr_addr_s = ADDR_WIDTH'(ADDR_OPB);
        wr_data_s = op_b_r;
        if (b_fire_s && !resp_is_err(m0_axi_bresp)) wr_start_s = 1'b1;
        else                                        wr_start_s = 1'b0;
      end
      default: wr_start_s = 1'b0;
    endcase
  end

  axi_lite_wr_chan #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wr_chan (
    .clk        (m0_axi_aclk),
    .rst_n      (m0_axi_aresetn),
    .start      (wr_start_s),
    .addr       (wr_addr_s),
    .data       (wr_data_s),
    .awaddr     (m0_axi_awaddr),
    .awvalid    (m0_axi_awvalid),
    .awready    (m0_axi_awready),
    .wdata      (m0_axi_wdata),
    .wvalid     (m0_axi_wvalid),
    .wready     (m0_axi_wready),
    .bready     (m0_axi_bready),
    .bvalid     (m0_axi_bvalid),
    .phase_done (wr_phase_done_s)
  );

  // Transaction sequencer with registered command, read and result outputs.
  always_ff @(posedge m0_axi_aclk or negedge m0_axi_aresetn) begin
    if (!m0_axi_aresetn) begin
      state_r        <= IDLE;
      op_b_r         <= {DATA_WIDTH{1'b0}};
      cmd_ready      <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= {DATA_WIDTH{1'b0}};
      res_err        <= 1'b0;
      m0_axi_araddr  <= {ADDR_WIDTH{1'b0}};
      m0_axi_arvalid <= 1'b0;
      m0_axi_rready  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_b_r    <= cmd_b;
            res_err   <= 1'b0;
            cmd_ready <= 1'b0;
            state_r   <= WR_A;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR_A: begin
          if (wr_phase_done_s) state_r <= RESP_A;
        end
        RESP_A: begin
          if (b_fire_s) begin
            if (resp_is_err(m0_axi_bresp)) begin
              res_err   <= 1'b1;
              res_data  <= {DATA_WIDTH{1'b0}};
              res_valid <= 1'b1;
              state_r   <= DONE;
            end else begin
              state_r   <= WR_B;
            end
          end
        end
        WR_B: begin
          if (wr_phase_done_s) state_r <= RESP_B;
        end
        RESP_B: begin
          if (b_fire_s) begin
            if (resp_is_err(m0_axi_bresp)) begin
              res_err   <= 1'b1;
              res_data  <= {DATA_WIDTH{1'b0}};
              res_valid <= 1'b1;
              state_r   <= DONE;
            end else begin
              m0_axi_araddr  <= ADDR_WIDTH'(ADDR_RESULT);
              m0_axi_arvalid <= 1'b1;
              state_r        <= RD_ADDR;
            end
          end
        end
        RD_ADDR: begin
          if (m0_axi_arready) begin
            m0_axi_arvalid <= 1'b0;
            m0_axi_rready  <= 1'b1;
            state_r        <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m0_axi_rvalid) begin
            m0_axi_rready <= 1'b0;
            res_valid     <= 1'b1;
            state_r       <= DONE;
            if (resp_is_err(m0_axi_rresp)) begin
              res_err  <= 1'b1;
              res_data <= {DATA_WIDTH{1'b0}};
            end else begin
              res_data <= m0_axi_rdata;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_axi_master.sv
// Scoreboard bench for adder_axi_master with a behavioural AXI4-Lite adder slave.
module tb_adder_axi_master;
  import adder_axi_pkg::*;

  localparam int DW = 32;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready, res_valid, res_ready, res_err;
  logic [DW-1:0] cmd_a, cmd_b, res_data;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0]    bresp, rresp;

  adder_axi_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .m0_axi_aclk(clk), .m0_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .m0_axi_awaddr(awaddr), .m0_axi_awvalid(awvalid), .m0_axi_awready(awready),
    .m0_axi_wdata(wdata), .m0_axi_wstrb(wstrb), .m0_axi_wvalid(wvalid), .m0_axi_wready(wready),
    .m0_axi_bresp(bresp), .m0_axi_bvalid(bvalid), .m0_axi_bready(bready),
    .m0_axi_araddr(araddr), .m0_axi_arvalid(arvalid), .m0_axi_arready(arready),
    .m0_axi_rdata(rdata), .m0_axi_rresp(rresp), .m0_axi_rvalid(rvalid), .m0_axi_rready(rready)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct { logic [DW-1:0] d; logic e; } exp_t;
  exp_t sb_q[$];

  // slave configuration
  int         aw_dly[2], w_dly[2];
  logic [1:0] bresp_cfg[2];
  logic [1:0] rresp_cfg;
  bit         r_hold;
  int         bp_cnt;

  // slave state and logs
  int          wr_idx, aw_cnt, w_cnt, aw_hs, w_hs, ar_hs;
  bit          aw_seen, w_seen;
  logic [DW-1:0] reg_a, reg_b;
  logic [AW-1:0] aw_log[$];
  logic [DW-1:0] w_log[$];
  logic [AW-1:0] ar_log[$];
  logic          awv_q, wv_q, br_q, arv_q, rr_q;
  logic [AW-1:0] awaddr_q, araddr_q;
  logic [DW-1:0] wdata_q;
  logic [DW/8-1:0] wstrb_q;

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); ar_log.delete();
    aw_hs = 0; w_hs = 0; ar_hs = 0; wr_idx = 0;
  endtask

  task automatic slave_clear();
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = OKAY;
    arready = 1'b1; rvalid = 1'b0; rresp = OKAY; rdata = '0;
    aw_cnt = 0; w_cnt = 0; aw_seen = 1'b0; w_seen = 1'b0; wr_idx = 0;
  endtask

  // Behavioural adder slave; handshakes at an edge are judged from values held across it.
  initial begin
    slave_clear();
    res_ready = 1'b1;
    {awv_q, wv_q, br_q, arv_q, rr_q} = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        slave_clear();
      end else begin
        int widx;
        if (awv_q && awready) begin
          aw_hs++; aw_log.push_back(awaddr_q); aw_seen = 1'b1; aw_cnt = 0;
        end else if (awv_q) aw_cnt++;
        if (wv_q && wready) begin
          w_hs++; w_log.push_back(wdata_q); w_seen = 1'b1; w_cnt = 0;
          chk("wstrb", 64'(wstrb_q), 64'hF);
        end else if (wv_q) w_cnt++;
        if (bvalid && br_q) begin
          bvalid = 1'b0;
          if (aw_log[$] == ADDR_OPA) reg_a = w_log[$];
          else                       reg_b = w_log[$];
          wr_idx++;
        end
        widx = (wr_idx > 1) ? 1 : wr_idx;
        if (aw_seen && w_seen) begin
          bvalid = 1'b1; bresp = bresp_cfg[widx]; aw_seen = 1'b0; w_seen = 1'b0;
        end
        awready = (aw_cnt >= aw_dly[widx]);
        wready  = (w_cnt  >= w_dly[widx]);
        if (rvalid && rr_q) rvalid = 1'b0;
        if (arv_q && arready) begin
          ar_hs++; ar_log.push_back(araddr_q);
          if (!r_hold) begin
            rvalid = 1'b1; rdata = reg_a + reg_b; rresp = rresp_cfg;
          end
        end
      end
      if (bp_cnt > 0 && res_valid) begin
        res_ready = 1'b0; bp_cnt--;
      end else begin
        res_ready = 1'b1;
      end
      awv_q = awvalid; wv_q = wvalid; br_q = bready; arv_q = arvalid; rr_q = rready;
      awaddr_q = awaddr; wdata_q = wdata; wstrb_q = wstrb; araddr_q = araddr;
    end
  end

  // Monitor: compares every result handshake against the scoreboard.
  int  hs_cyc, res_hs_cyc;
  bit  lat_chk, cr_next_chk, rv_prev;
  initial begin
    lat_chk = 1'b0; cr_next_chk = 1'b0; rv_prev = 1'b0; res_hs_cyc = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cr_next_chk) begin
          chk("cmd_ready_after_res", 64'(cmd_ready), 64'd1);
          cr_next_chk = 1'b0;
        end
        if (res_valid) chk("cmd_ready_in_done", 64'(cmd_ready), 64'd0);
        if (res_valid && !rv_prev && lat_chk) begin
          chk("latency", 64'(cyc - hs_cyc), 64'd7);
          lat_chk = 1'b0;
        end
        if (res_valid && res_ready) begin
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_result: got data %0h with empty scoreboard", res_data);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("res_data", 64'(res_data), 64'(e.d));
            chk("res_err", 64'(res_err), 64'(e.e));
          end
          res_hs_cyc  = cyc;
          cr_next_chk = 1'b1;
        end else if (res_valid && sb_q.size() > 0) begin
          chk("res_data_hold", 64'(res_data), 64'(sb_q[0].d));
        end
        rv_prev = res_valid;
      end else begin
        rv_prev = 1'b0; cr_next_chk = 1'b0;
      end
    end
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] ed, input logic ee, input bit hold);
    int n;
    exp_t e;
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept_timeout: cmd_ready stayed 0 for %0d cycles", n);
    end else begin
      e.d = ed; e.e = ee;
      sb_q.push_back(e);
      hs_cyc = cyc;
    end
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL result_timeout: %0d results still pending", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] qa(input int i);
    return (aw_log.size() > i) ? 64'(aw_log[i]) : 64'hEE;
  endfunction
  function automatic logic [63:0] qw(input int i);
    return (w_log.size() > i) ? 64'(w_log[i]) : 64'hDEAD_BEEF_0;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
    aw_dly[0] = 0; aw_dly[1] = 0; w_dly[0] = 0; w_dly[1] = 0;
    bresp_cfg[0] = OKAY; bresp_cfg[1] = OKAY; rresp_cfg = OKAY; r_hold = 1'b0; bp_cnt = 0;
    reg_a = '0; reg_b = '0; hs_cyc = 0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_err", 64'(res_err), 64'd0);
    chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("rst_addrs", 64'({awaddr, araddr}), 64'd0);
    chk("rst_wstrb", 64'(wstrb), 64'hF);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // basic add
    clear_logs(); lat_chk = 1'b1;
    send(32'd5, 32'd7, 32'd12, 1'b0, 1'b0);
    wait_done();
    chk("basic_aw_hs", 64'(aw_hs), 64'd2);
    chk("basic_w_hs", 64'(w_hs), 64'd2);
    chk("basic_ar_hs", 64'(ar_hs), 64'd1);
    chk("basic_awaddr_a", qa(0), 64'h00);
    chk("basic_awaddr_b", qa(1), 64'h04);
    chk("basic_wdata_a", qw(0), 64'd5);
    chk("basic_wdata_b", qw(1), 64'd7);
    chk("basic_araddr", (ar_log.size() > 0) ? 64'(ar_log[0]) : 64'hEE, 64'h08);

    // skewed handshakes
    clear_logs();
    aw_dly[0] = 0; w_dly[0] = 3; aw_dly[1] = 2; w_dly[1] = 0;
    send(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
    wait_done();
    chk("skew_aw_hs", 64'(aw_hs), 64'd2);
    chk("skew_w_hs", 64'(w_hs), 64'd2);
    chk("skew_wdata_a", qw(0), 64'hFFFF_FFFF);
    chk("skew_wdata_b", qw(1), 64'd1);
    chk("skew_awaddr_b", qa(1), 64'h04);
    aw_dly[0] = 0; w_dly[0] = 0; aw_dly[1] = 0; w_dly[1] = 0;

    // write error on A
    clear_logs();
    bresp_cfg[0] = SLVERR;
    send(32'd11, 32'd22, 32'd0, 1'b1, 1'b0);
    wait_done();
    chk("werr_aw_hs", 64'(aw_hs), 64'd1);
    chk("werr_w_hs", 64'(w_hs), 64'd1);
    chk("werr_ar_hs", 64'(ar_hs), 64'd0);
    bresp_cfg[0] = OKAY;

    // result backpressure with the next command already waiting
    clear_logs();
    bp_cnt = 5;
    send(32'd10, 32'd20, 32'd30, 1'b0, 1'b1);
    send(32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    chk("next_cmd_gap", 64'(hs_cyc - res_hs_cyc), 64'd1);
    wait_done();
    chk("bp_ar_hs", 64'(ar_hs), 64'd2);

    // reset while waiting for read data
    clear_logs();
    r_hold = 1'b1;
    send(32'd9, 32'd9, 32'd18, 1'b0, 1'b0);
    n = 0;
    while (!rready && n < 100) begin @(posedge clk); #1; n++; end
    chk("reach_rd_data", 64'(rready), 64'd1);
    #2; rst_n = 1'b0; #1;
    chk("midrst_arvalid", 64'(arvalid), 64'd0);
    chk("midrst_rready", 64'(rready), 64'd0);
    chk("midrst_res_valid", 64'(res_valid), 64'd0);
    chk("midrst_wr_valids", 64'({awvalid, wvalid, bready}), 64'd0);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
    sb_q.delete();
    r_hold = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    send(32'd3, 32'd4, 32'd7, 1'b0, 1'b0);
    wait_done();
    chk("post_rst_aw_hs", 64'(aw_hs), 64'd2);
    chk("post_rst_ar_hs", 64'(ar_hs), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
